c_wf_alloc_mc: RTL and testbench
================================

# c_wf_alloc_mc

Multi-cycle, rectangular wavefront allocator for routers whose port counts are too large for a single-cycle diagonal-propagation wavefront. It captures one request matrix per allocation and sweeps the priority diagonals over several cycles, `diags_per_cycle` diagonals per cycle, carrying row/column availability in registers. It returns a registered grant matrix through a valid/ready handshake. Priority levels are resolved in strict order, and the priority diagonal rotates only after an allocation that granted something.

## Interface
- `num_inputs`, 8: request rows.
- `num_outputs`, 8: grant columns.
- `num_priorities`, 1: priority levels; level 0 is highest.
- `diags_per_cycle`, 2: diagonals evaluated per cycle (G).
- Derived:
  - D = max(`num_inputs`, `num_outputs`).
  - S = D/G.
  - D % G must equal 0; violation is an elaboration error.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset.
- `active`  in  1  register enable; when low, all state holds.
- `req_valid`  in  1  request matrix offered.
- `req_ready`  out  1  allocator idle and able to capture.
- `req_pr`  in  `num_priorities`*`num_inputs`*`num_outputs`  request matrices, row-major per level.
- `gnt_valid`  out  1  result available.
- `gnt_ready`  in  1  result consumed.
- `gnt_pr`  out  same width as `req_pr`  per-level grants.
- `gnt`  out  `num_inputs`*`num_outputs`  OR of all levels.
- `gnt_any`  out  1  OR of `gnt`.

## Operation
- Cell (i,j) lies on diagonal (i+j) mod D.
- Cells on one diagonal share no row or column, so all of them resolve in parallel.
- Priority index `prio_q`: $clog2(D) bits, reset value 0.
- States: IDLE, RUN, DONE.
  - `req_ready` = (state==IDLE) & `active`.
  - `gnt_valid` = (state==DONE).
- Capture, on IDLE with req_valid&req_ready:
  - `req_q` <= `req_pr`.
  - `row_free` <= all 1; `col_free` <= all 1.
  - `gnt_pr` register <= 0.
  - Step counter <= 0.
  - State -> RUN.
- RUN step n, where level p = n / S and s = n % S:
  - Evaluate diagonals (`prio_q` + s*G + g) mod D, for g = 0..G-1, in g order.
  - A cell is granted when its `req_q`[p] bit, its row_free bit and its col_free bit are all 1.
  - A granted cell clears its row and column for later diagonals in the same cycle.
  - Results are OR'ed into `gnt_pr`[p].
  - Free vectors update; counter increments.
- Exit RUN to DONE when either:
  - n == `num_priorities`*S-1, or
  - the post-step `row_free` == 0, or
  - the post-step `col_free` == 0.
- DONE:
  - Outputs hold.
  - On `gnt_ready`, state -> IDLE.
  - If `gnt_any`=1, `prio_q` updates (see Configuration); otherwise `prio_q` is unchanged.
- Boundary conditions:
  - Rows or columns beyond `num_inputs`/`num_outputs` inside the D×D space are treated as never-requesting.
  - An empty request matrix runs all `num_priorities`*S steps, giving `gnt_any`=0.
  - `req_valid` outside IDLE is ignored.
  - `gnt_ready` outside DONE is ignored.
- `active`=0: no register changes, `req_ready`=0, `gnt_ready` ignored, `gnt_valid` reflects the held state.
- `reset`=0 at any edge, including mid-RUN:
  - State -> IDLE.
  - `prio_q`=0.
  - `gnt_pr`, `row_free`, `col_free` and counter cleared.
  - Outputs: `req_ready`=1 (if `active`), `gnt_valid`=0, `gnt`=0, `gnt_any`=0.

## Timing
- Capture in cycle c; RUN occupies cycles c+1..c+k, with 1 ≤ k ≤ `num_priorities`*S.
- `gnt_valid` rises in cycle c+k+1.
- Registered outputs are stable from c+k+1 until the handshake.
- The next capture is possible one cycle after the `gnt` handshake.
- Minimum period per allocation is k+2 cycles.
- No combinational path from `req_pr` to any output.

## Configuration
- `C_WF_ALLOC_SKIP_EMPTY_DIAGS_EN` defined:
  - next `prio_q` = (f+1) mod D.
  - f = first diagonal at or after `prio_q` (cyclic) that holds any `req_q` bit of the highest-priority non-empty level.
  - f is computed combinationally from `req_q`.
- Undefined: next `prio_q` = (`prio_q`+1) mod D.
- In both cases the update happens only on a DONE handshake with `gnt_any`=1.

## Structure
- Package `c_wf_alloc_pkg`:
  - state enum typedef (IDLE/RUN/DONE).
  - diagonal-index function (i+j) mod D.
  - clog2-based width constants.
- Sub-module `c_wf_alloc_diag_step`:
  - combinational; inputs: G diagonal indices, one request level, `row_free`/`col_free`.
  - outputs: step grants and next free vectors.
- Top level holds the FSM, counter, `req_q`, free and grant registers, and the priority update.

## Test plan
1. Reset: hold `reset`=0 for 2 cycles with `active`=1 -> `req_ready`=1, `gnt_valid`=0, `gnt`=0, `prio_q`=0.
2. Full matrix, 4×4, G=2, 1 level:
   - Stimulus: all-ones request, captured at c.
   - Required: k=1; `gnt_valid` at c+2.
   - Grants at (0,0), (1,3), (2,2), (3,1).
   - After handshake, `prio_q`=1.
3. Single request (2,1), diagonal 3, 4×4, G=2:
   - Required: k=2; `gnt_valid` at c+3; `gnt`=(2,1) only.
   - Next `prio_q`: 0 with the macro, 1 without.
4. Priority levels, `num_priorities`=2:
   - Stimulus: level 0 requests (0,1); level 1 requests (0,0).
   - Required: `gnt_pr` level0 = (0,1); level1 = 0.
5. Backpressure:
   - Stimulus: `gnt_ready`=0 for 5 cycles, with `req_valid` pulsed meanwhile.
   - Required: `gnt` stable, `req_ready`=0, request not captured, `prio_q` unchanged.
6. Reset mid-RUN and empty request:
   - Reset in cycle c+1 -> IDLE next cycle with outputs at reset values.
   - All-zero request -> k=`num_priorities`*S, `gnt_any`=0, `prio_q` unchanged after handshake.

Source files
------------

// File: rtl/c_wf_alloc_mc_pkg.sv
// Shared types and helpers for the multi-cycle wavefront allocator.
package c_wf_alloc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index width for a range of n values; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int diag_of(input int i, input int j, input int d);
    return (i + j) % d;
  endfunction

endpackage

// File: rtl/c_wf_alloc_mc_if.sv
// Request/grant bus of the wavefront allocator.
// Both channels use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both 1; the source holds its payload until then.
interface c_wf_alloc_mc_if #(
  parameter int num_inputs     = 8,
  parameter int num_outputs    = 8,
  parameter int num_priorities = 1
);
  localparam int pw = num_priorities * num_inputs * num_outputs;

  logic                              req_valid;
  logic                              req_ready;
  logic [pw-1:0]                     req_pr;
  logic                              gnt_valid;
  logic                              gnt_ready;
  logic [pw-1:0]                     gnt_pr;
  logic [num_inputs*num_outputs-1:0] gnt;
  logic                              gnt_any;

  modport master (
    output req_valid, req_pr, gnt_ready,
    input  req_ready, gnt_valid, gnt_pr, gnt, gnt_any
  );

  modport slave (
    input  req_valid, req_pr, gnt_ready,
    output req_ready, gnt_valid, gnt_pr, gnt, gnt_any
  );
endinterface

// File: rtl/c_wf_alloc_mc_diag_step.sv
// One RUN step: resolves diags_per_cycle diagonals in order against one request level.
module c_wf_alloc_diag_step
  import c_wf_alloc_pkg::*;
#(
  parameter int num_inputs      = 8,
  parameter int num_outputs     = 8,
  parameter int d_size          = 8,
  parameter int diags_per_cycle = 2,
  localparam int idx_bits       = idx_w(d_size)
) (
  input  logic [diags_per_cycle-1:0][idx_bits-1:0] diag,
  input  logic [num_inputs*num_outputs-1:0]        req,
  input  logic [d_size-1:0]                        row_free,
  input  logic [d_size-1:0]                        col_free,
  output logic [num_inputs*num_outputs-1:0]        step_gnt,
  output logic [d_size-1:0]                        row_next,
  output logic [d_size-1:0]                        col_next
);

  // Cells of one diagonal never share a row or column, so clearing as we go
  // only affects the diagonals evaluated after it.
  always_comb begin
    step_gnt = '0;
    row_next = row_free;
    col_next = col_free;
    for (int g = 0; g < diags_per_cycle; g++) begin
      for (int i = 0; i < num_inputs; i++) begin
        for (int j = 0; j < num_outputs; j++) begin
          if ((diag_of(i, j, d_size) == int'(diag[g])) && req[i*num_outputs+j] &&
              row_next[i] && col_next[j]) begin
            step_gnt[i*num_outputs+j] = 1'b1;
            row_next[i] = 1'b0;
            col_next[j] = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/c_wf_alloc_mc.sv
// Multi-cycle rectangular wavefront allocator with rotating priority diagonal.
// Optional: C_WF_ALLOC_SKIP_EMPTY_DIAGS_EN rotates past diagonals with no requests.
module c_wf_alloc_mc
  import c_wf_alloc_pkg::*;
#(
  parameter int num_inputs      = 8,
  parameter int num_outputs     = 8,
  parameter int num_priorities  = 1,
  parameter int diags_per_cycle = 2,
  localparam int d_size = (num_inputs > num_outputs) ? num_inputs : num_outputs,
  localparam int prio_w = idx_w(d_size)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  c_wf_alloc_mc_if.slave    bus,
  output state_e            state_dbg,
  output logic [prio_w-1:0] prio_dbg
);

  localparam int s_steps = d_size / diags_per_cycle;
  localparam int lw      = num_inputs * num_outputs;
  localparam int pw      = num_priorities * lw;
  localparam int sub_w   = idx_w(s_steps);
  localparam int lvl_w   = idx_w(num_priorities);

  if (d_size % diags_per_cycle != 0) begin : g_bad_cfg
    $error("c_wf_alloc_mc: max(num_inputs,num_outputs) must be a multiple of diags_per_cycle");
  end

  state_e                 state;
  logic [pw-1:0]          req_q;
  logic [pw-1:0]          gnt_pr_q;
  logic [d_size-1:0]      row_free;
  logic [d_size-1:0]      col_free;
  logic [lvl_w-1:0]       lvl;
  logic [sub_w-1:0]       sub;
  logic [prio_w-1:0]      prio_q;
  logic [prio_w-1:0]      prio_next;
  logic                   gnt_valid_q;

  logic [diags_per_cycle-1:0][prio_w-1:0] diag_idx;
  logic [lw-1:0]          lvl_req;
  logic [lw-1:0]          step_gnt;
  logic [d_size-1:0]      row_next;
  logic [d_size-1:0]      col_next;
  logic [lw-1:0]          gnt_or;
  logic                   last_step;

  always_comb begin
    for (int g = 0; g < diags_per_cycle; g++) begin
      diag_idx[g] = prio_w'((int'(prio_q) + int'(sub) * diags_per_cycle + g) % d_size);
    end
  end

  assign lvl_req   = req_q[int'(lvl)*lw +: lw];
  assign last_step = (int'(lvl) == num_priorities - 1) && (int'(sub) == s_steps - 1);

  c_wf_alloc_diag_step #(
    .num_inputs      (num_inputs),
    .num_outputs     (num_outputs),
    .d_size          (d_size),
    .diags_per_cycle (diags_per_cycle)
  ) u_step (
    .diag     (diag_idx),
    .req      (lvl_req),
    .row_free (row_free),
    .col_free (col_free),
    .step_gnt (step_gnt),
    .row_next (row_next),
    .col_next (col_next)
  );

  always_comb begin
    gnt_or = '0;
    for (int p = 0; p < num_priorities; p++) begin
      gnt_or = gnt_or | gnt_pr_q[p*lw +: lw];
    end
  end

`ifdef C_WF_ALLOC_SKIP_EMPTY_DIAGS_EN
  logic [lw-1:0]     top_req;
  logic [d_size-1:0] diag_occ;
  logic [prio_w-1:0] first_diag;
  logic [prio_w-1:0] scan_d;
  logic              found_lvl;
  logic              found_diag;

  // Next priority starts just past the first occupied diagonal of the
  // highest non-empty level, scanning cyclically from the current one.
  always_comb begin
    top_req   = '0;
    found_lvl = 1'b0;
    for (int p = 0; p < num_priorities; p++) begin
      if (!found_lvl && (|req_q[p*lw +: lw])) begin
        top_req   = req_q[p*lw +: lw];
        found_lvl = 1'b1;
      end
    end
    diag_occ = '0;
    for (int d = 0; d < d_size; d++) begin
      for (int i = 0; i < num_inputs; i++) begin
        for (int j = 0; j < num_outputs; j++) begin
          if ((diag_of(i, j, d_size) == d) && top_req[i*num_outputs+j]) diag_occ[d] = 1'b1;
        end
      end
    end
    first_diag = prio_q;
    found_diag = 1'b0;
    scan_d     = '0;
    for (int t = 0; t < d_size; t++) begin
      scan_d = prio_w'((int'(prio_q) + t) % d_size);
      if (!found_diag && diag_occ[scan_d]) begin
        first_diag = scan_d;
        found_diag = 1'b1;
      end
    end
    prio_next = prio_w'((int'(first_diag) + 1) % d_size);
  end
`else
  assign prio_next = prio_w'((int'(prio_q) + 1) % d_size);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      req_q       <= '0;
      gnt_pr_q    <= '0;
      row_free    <= '0;
      col_free    <= '0;
      lvl         <= '0;
      sub         <= '0;
      prio_q      <= '0;
      gnt_valid_q <= 1'b0;
    end else if (active) begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            req_q    <= bus.req_pr;
            row_free <= '1;
            col_free <= '1;
            gnt_pr_q <= '0;
            lvl      <= '0;
            sub      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          gnt_pr_q[int'(lvl)*lw +: lw] <= gnt_pr_q[int'(lvl)*lw +: lw] | step_gnt;
          row_free <= row_next;
          col_free <= col_next;
          if (last_step || (row_next == '0) || (col_next == '0)) begin
            state       <= DONE;
            gnt_valid_q <= 1'b1;
          end else if (int'(sub) == s_steps - 1) begin
            sub <= '0;
            lvl <= lvl + 1'b1;
          end else begin
            sub <= sub + 1'b1;
          end
        end
        DONE: begin
          if (bus.gnt_ready) begin
            state       <= IDLE;
            gnt_valid_q <= 1'b0;
            if (|gnt_or) prio_q <= prio_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE) && active;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_pr    = gnt_pr_q;
  assign bus.gnt       = gnt_or;
  assign bus.gnt_any   = |gnt_or;
  assign state_dbg     = state;
  assign prio_dbg      = prio_q;

endmodule

// File: tb/tb_c_wf_alloc_mc.sv
// Bench for c_wf_alloc_mc: directed plan steps plus randomized allocations
// compared with a diagonal-sweep reference model.
module tb_c_wf_alloc_mc;
  import c_wf_alloc_pkg::*;

  localparam int NI = 4;
  localparam int NO = 4;
  localparam int NP = 2;
  localparam int G  = 2;
  localparam int D  = (NI > NO) ? NI : NO;
  localparam int L  = NI * NO;
  localparam int PW = NP * L;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic active;
  always #5 clk = ~clk;

  c_wf_alloc_mc_if #(.num_inputs(NI), .num_outputs(NO), .num_priorities(NP)) bus ();
  state_e     state_dbg;
  logic [1:0] prio_dbg;

  c_wf_alloc_mc #(
    .num_inputs      (NI),
    .num_outputs     (NO),
    .num_priorities  (NP),
    .diags_per_cycle (G)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .active    (active),
    .bus       (bus),
    .state_dbg (state_dbg),
    .prio_dbg  (prio_dbg)
  );

  // scoreboard
  int            errors = 0;
  int            checks = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] cur_req;
  logic [PW-1:0] cur_gp;
  int            cur_k;
  int            model_prio = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Reference: walk diagonals in priority order (level-major, rotated by prio);
  // allocation ends at the first step boundary where rows or columns run out.
  task automatic model_alloc(input logic [PW-1:0] req, input int prio,
                             output logic [PW-1:0] gp, output int k);
    bit row_used [D];
    bit col_used [D];
    int rows_left;
    int cols_left;
    bit done;
    gp = '0;
    k = NP * (D / G);
    rows_left = D;
    cols_left = D;
    done = 1'b0;
    for (int r = 0; r < D; r++) begin
      row_used[r] = 1'b0;
      col_used[r] = 1'b0;
    end
    for (int t = 0; t < NP * D; t++) begin
      int p;
      int d;
      p = t / D;
      d = (prio + (t % D)) % D;
      if (!done) begin
        for (int i = 0; i < NI; i++) begin
          for (int j = 0; j < NO; j++) begin
            if (((i + j) % D == d) && req[p*L + i*NO + j] && !row_used[i] && !col_used[j]) begin
              gp[p*L + i*NO + j] = 1'b1;
              row_used[i] = 1'b1;
              col_used[j] = 1'b1;
              rows_left--;
              cols_left--;
            end
          end
        end
        if ((t % G == G - 1) && (rows_left == 0 || cols_left == 0)) begin
          k = t / G + 1;
          done = 1'b1;
        end
      end
    end
  endtask

  function automatic int next_prio(input logic [PW-1:0] req, input int prio,
                                   input logic [PW-1:0] gp);
    if (gp == '0) return prio;
`ifdef C_WF_ALLOC_SKIP_EMPTY_DIAGS_EN
    for (int p = 0; p < NP; p++) begin
      if (req[p*L +: L] != '0) begin
        for (int t = 0; t < D; t++) begin
          int d;
          d = (prio + t) % D;
          for (int i = 0; i < NI; i++)
            for (int j = 0; j < NO; j++)
              if (((i + j) % D == d) && req[p*L + i*NO + j]) return (d + 1) % D;
        end
      end
    end
    return prio;
`else
    return (prio + 1) % D;
`endif
  endfunction

  function automatic logic [L-1:0] or_levels(input logic [PW-1:0] gp);
    logic [L-1:0] r;
    r = '0;
    for (int p = 0; p < NP; p++) r = r | gp[p*L +: L];
    return r;
  endfunction

  // driver: capture a request, optionally stall with active=0, check the result
  task automatic send(input logic [PW-1:0] req, input int stall, input string tag);
    int n;
    int lat;
    logic [PW-1:0] want;
    model_alloc(req, model_prio, cur_gp, cur_k);
    cur_req = req;
    exp_q.push_back(cur_gp);
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_ready"}, bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_pr    = req;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_pr    = PW'($urandom);
    for (int c = 0; c < stall; c++) begin
      active = 1'b0;
      bus.gnt_ready = 1'b1;
      @(negedge clk);
      check({tag, "_stall_state"}, state_dbg, RUN);
      check({tag, "_stall_ready"}, bus.req_ready, 1'b0);
    end
    active = 1'b1;
    bus.gnt_ready = 1'b0;
    lat = 0;
    while (!bus.gnt_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, cur_k);
    want = exp_q.pop_front();
    check({tag, "_gnt_pr"}, bus.gnt_pr, want);
    check({tag, "_gnt"}, bus.gnt, or_levels(want));
    check({tag, "_gnt_any"}, bus.gnt_any, (want != '0));
  endtask

  task automatic finish_alloc(input int hold, input string tag);
    for (int c = 0; c < hold; c++) begin
      active = 1'b0;
      bus.gnt_ready = 1'b1;
      @(negedge clk);
      check({tag, "_hold_valid"}, bus.gnt_valid, 1'b1);
    end
    active = 1'b1;
    bus.gnt_ready = 1'b1;
    @(negedge clk);
    bus.gnt_ready = 1'b0;
    model_prio = next_prio(cur_req, model_prio, cur_gp);
    check({tag, "_prio"}, prio_dbg, model_prio);
    check({tag, "_valid_drop"}, bus.gnt_valid, 1'b0);
    check({tag, "_ready_back"}, bus.req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] r;
    logic [PW-1:0] bp_gnt;
    int mode;
    bus.req_valid = 1'b0;
    bus.req_pr    = '0;
    bus.gnt_ready = 1'b0;
    active        = 1'b1;

    // 1. reset
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_gnt_valid", bus.gnt_valid, 1'b0);
    check("rst_gnt", bus.gnt, '0);
    check("rst_prio", prio_dbg, 2'd0);
    reset = 1'b1;
    @(negedge clk);

    // 2. full matrix on level 0, prio 0: one step, diagonal 0 wins
    send({16'h0000, 16'hFFFF}, 0, "full");
    check("full_const_gnt_pr", bus.gnt_pr, 32'h0000_2481);
    finish_alloc(0, "full");
    check("full_const_prio", prio_dbg, 2'd1);

    // 3. single request at (2,1)
    send(32'h0000_0200, 0, "single");
    check("single_const_gnt", bus.gnt, 16'h0200);
    finish_alloc(1, "single");

    // 4. two levels: level 0 (0,1) blocks level 1 (0,0)
    send(32'h0001_0002, 0, "levels");
    check("levels_const_gnt_pr", bus.gnt_pr, 32'h0000_0002);
    finish_alloc(0, "levels");

    // 5. backpressure with request pulses while DONE
    send(32'h8421_1248, 1, "bp");
    bp_gnt = cur_gp;
    for (int c = 0; c < 5; c++) begin
      bus.req_valid = (c % 2 == 0);
      bus.req_pr    = PW'($urandom);
      @(negedge clk);
      check("bp_gnt_stable", bus.gnt_pr, bp_gnt);
      check("bp_req_ready", bus.req_ready, 1'b0);
      check("bp_prio", prio_dbg, model_prio);
      check("bp_state", state_dbg, DONE);
    end
    bus.req_valid = 1'b0;
    finish_alloc(0, "bp");
    @(negedge clk);
    check("bp_not_captured", state_dbg, IDLE);

    // 6a. reset in the cycle after capture
    bus.req_valid = 1'b1;
    bus.req_pr    = '0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("mid_state_run", state_dbg, RUN);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_prio = 0;
    check("mid_state_idle", state_dbg, IDLE);
    check("mid_req_ready", bus.req_ready, 1'b1);
    check("mid_gnt_valid", bus.gnt_valid, 1'b0);
    check("mid_gnt", bus.gnt, '0);
    check("mid_gnt_any", bus.gnt_any, 1'b0);
    check("mid_prio", prio_dbg, 2'd0);

    // 6b. empty request after moving prio away from 0
    send({16'h0000, 16'hFFFF}, 0, "full2");
    finish_alloc(0, "full2");
    send('0, 0, "empty");
    check("empty_const_latency_gnt_any", bus.gnt_any, 1'b0);
    finish_alloc(0, "empty");
    check("empty_const_prio", prio_dbg, 2'd1);

    // randomized allocations
    for (int it = 0; it < 30; it++) begin
      r = '0;
      for (int p = 0; p < NP; p++) begin
        mode = $urandom_range(0, 3);
        for (int b = 0; b < L; b++) begin
          case (mode)
            1:       r[p*L + b] = ($urandom_range(0, 7) == 0);
            2:       r[p*L + b] = ($urandom_range(0, 1) == 0);
            3:       r[p*L + b] = ($urandom_range(0, 3) != 0);
            default: r[p*L + b] = 1'b0;
          endcase
        end
      end
      send(r, $urandom_range(0, 2), "rnd");
      finish_alloc($urandom_range(0, 2), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
